perf_counters_multi: RTL
========================

# perf_counters_multi

Multi-channel performance counter bank, the parametrised successor to the single-channel software-request counter. Each of `NUM_CH` channels counts CPU trigger pulses. Software reads one channel at a time through a request/valid handshake; a read returns a registered snapshot, a sticky overflow flag and an error indication, and clears the channel. The block sits between the CPU event sources and the software-visible register interface.

## Interface
- `NUM_CH`, 4: number of counter channels; legal range 2..16.
- `CNT_W`, 8: counter width in bits; legal range 2..32.
- `CH_W`, `$clog2(NUM_CH)`: derived channel-select width; not overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_trig_i`  in  NUM_CH  per-channel event pulse; each set bit is one event in that cycle.
- `cnt_en_i`  in  1  global count enable; events are ignored while low.
- `rd_req_i`  in  1  single-cycle read request.
- `rd_ch_i`  in  CH_W  channel selected for read; sampled with `rd_req_i`.
- `rd_valid_o`  out  1  read response valid, one cycle.
- `rd_data_o`  out  CNT_W  snapshot count of the selected channel.
- `rd_ovf_o`  out  1  overflow flag of the selected channel at snapshot time.
- `rd_err_o`  out  1  the selected channel was out of range (`rd_ch_i >= NUM_CH`).

## Operation
- Per channel: `count_q[CNT_W]` and `ovf_q` (sticky).
- Increment: when `cnt_en_i & cpu_trig_i[c]`, `count_q[c] <= count_q[c] + 1` in `CNT_W`-bit arithmetic.
- Overflow: an increment at all-ones sets `ovf_q[c]`. The count result depends on the configuration (see Configuration).
- Read with a valid channel (`rd_req_i`, `rd_ch_i < NUM_CH`):
  - The response captures `count_q` and `ovf_q` as they stood before this cycle's update.
  - The channel is cleared: `ovf_q <= 0`, and `count_q <= {0, event}`, where event = `cnt_en_i & cpu_trig_i[c]`. An event in the read cycle is never lost; it becomes the first count after the clear.
  - An overflow caused by that same-cycle event cannot occur, because the count restarts from 0.
- Read with an invalid channel: `rd_data_o = 0`, `rd_ovf_o = 0`, `rd_err_o = 1`. No channel is modified.
- Other channels count normally during any read.
- Back-to-back requests on consecutive cycles are legal. Each produces its own response, so a fully pipelined read stream is supported. There is no backpressure.

## Timing
- Reset values: all `count_q` and `ovf_q` = 0; `rd_valid_o` = 0, `rd_data_o` = 0, `rd_ovf_o` = 0, `rd_err_o` = 0.
- Read latency is 1 cycle: a request at edge N produces `rd_valid_o` = 1 and stable data during cycle N+1.
- `rd_data_o`, `rd_ovf_o` and `rd_err_o` are zero whenever `rd_valid_o` = 0.
- Reset asserted mid-operation clears everything at the next edge. A request in the same cycle as `reset` is dropped, with no response.
- Back-to-back reads of the same channel: the second read returns only the events counted since the first read, including any event in the first read's cycle.

## Configuration
- Macro `PERF_CNT_SAT_EN`.
- When defined: counters saturate. An increment at all-ones holds the count at all-ones and sets `ovf_q`.
- When not defined: counters wrap. An increment at all-ones produces 0 and sets `ovf_q`.
- The read, clear and error behaviour is identical in both builds.

## Structure
- Package `perf_cnt_pkg` holds:
  - the parameter range limits;
  - the typedef of the read-response struct (`valid`, `data`, `ovf`, `err`), used for the registered output stage.
- Sub-module `perf_cnt_chan`: one counter plus its overflow flag, with `inc`, `clr` and `cnt_o`/`ovf_o`. It is instantiated `NUM_CH` times in a generate loop.
- The top level contains the read mux, the range check and the registered response.

## Test plan
All scenarios use `NUM_CH` = 4, `CNT_W` = 4.
- Reset, then 5 pulses on ch1 with `cnt_en_i` = 1, then read ch1 → `rd_valid_o` one cycle later, `rd_data_o` = 5, `rd_ovf_o` = 0. A second read of ch1 returns 0.
- 17 pulses on ch0 → without the macro: data = 1, ovf = 1. With `PERF_CNT_SAT_EN`: data = 15, ovf = 1. A follow-up read returns data = 0, ovf = 0.
- Continuous `cpu_trig_i[2]` = 1 with reads of ch2 at cycles 4 and 8 → first read returns 4, second returns 4. No events are lost across the clear.
- `cnt_en_i` = 0 while pulsing all channels for 6 cycles → reads of ch0..ch3 all return 0. Back-to-back reads on 4 consecutive cycles yield 4 consecutive valid responses.
- On a 3-channel build (`NUM_CH` = 3), a read of `rd_ch_i` = 3 → `rd_err_o` = 1 and data = 0. The contents of ch0..ch2 are unchanged on subsequent reads.
- Pulses on ch3 to reach a count of 7, then `reset` asserted together with `rd_req_i` → no `rd_valid_o`, and a later read of ch3 returns 0.

Source files
------------

// File: rtl/perf_cnt_pkg.sv
// rtl/perf_cnt_pkg.sv - shared limits and read-response type for the perf counter bank
package perf_cnt_pkg;

    // Legal parameter ranges for the counter bank
    localparam int NUM_CH_MIN = 2;
    localparam int NUM_CH_MAX = 16;
    localparam int CNT_W_MIN  = 2;
    localparam int CNT_W_MAX  = 32;

    // Registered read response; data is sized for the widest legal counter
    typedef struct packed {
        logic                 valid;
        logic [CNT_W_MAX-1:0] data;
        logic                 ovf;
        logic                 err;
    } rd_resp_t;

endpackage

// File: rtl/perf_cnt_chan.sv
// rtl/perf_cnt_chan.sv - one event counter with sticky overflow; PERF_CNT_SAT_EN selects saturate vs wrap
module perf_cnt_chan
    import perf_cnt_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    // Count events; a clear restarts from the same-cycle event so none is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= CNT_W'(inc);
            ovf_q <= 1'b0;
        end else if (inc) begin
            if (cnt_q == '1) begin
                ovf_q <= 1'b1;
`ifdef PERF_CNT_SAT_EN
                cnt_q <= cnt_q;
`else
                cnt_q <= '0;
`endif
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counters_multi.sv
// rtl/perf_counters_multi.sv - multi-channel perf counter bank with clear-on-read; PERF_CNT_SAT_EN enables saturation
module perf_counters_multi
    import perf_cnt_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] cpu_trig_i,
    input  logic              cnt_en_i,
    input  logic              rd_req_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic              rd_ovf_o,
    output logic              rd_err_o
);

    logic [CNT_W-1:0]     cnt_all [NUM_CH];
    logic [NUM_CH-1:0]    ovf_all;
    logic [NUM_CH-1:0]    clr;
    logic                 ch_ok;
    logic [CNT_W-1:0]     sel_cnt;
    logic                 sel_ovf;
    rd_resp_t             resp_d;
    rd_resp_t             resp_q;
    logic [CNT_W_MAX-1:0] unused_resp_data;

    // Channel select can encode values beyond NUM_CH when NUM_CH is not a power of two
    assign ch_ok = int'(rd_ch_i) < NUM_CH;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        assign clr[c] = rd_req_i && (int'(rd_ch_i) == c);

        perf_cnt_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .inc   (cnt_en_i & cpu_trig_i[c]),
            .clr   (clr[c]),
            .cnt_o (cnt_all[c]),
            .ovf_o (ovf_all[c])
        );
    end

    // Read mux: pre-update count and overflow of the selected channel
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(rd_ch_i) == c) begin
                sel_cnt = cnt_all[c];
                sel_ovf = ovf_all[c];
            end
        end
    end

    // Build the response; payload stays zero unless a valid read is returned
    always_comb begin
        resp_d       = '0;
        resp_d.valid = rd_req_i;
        if (rd_req_i) begin
            if (ch_ok) begin
                resp_d.data = CNT_W_MAX'(sel_cnt);
                resp_d.ovf  = sel_ovf;
            end else begin
                resp_d.err  = 1'b1;
            end
        end
    end

    // Registered response stage; a request coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign rd_valid_o       = resp_q.valid;
    assign rd_data_o        = resp_q.data[CNT_W-1:0];
    assign rd_ovf_o         = resp_q.ovf;
    assign rd_err_o         = resp_q.err;
    assign unused_resp_data = resp_q.data;

endmodule
